mem_arbiter: RTL

- Single-port memory arbiter and sequencer between the instruction-cache and data-cache request ports and the one shared RAM port.
- Grants one requester at a time, holds the grant until the RAM reports ACCESS, and returns the wait/load handshake to the winner.
- Sits below the caches and datapath: the datapath's imemREN/imemaddr and dmemREN/dmemWEN/dmemaddr/dmemstore traffic funnels through it.
- Data has priority; a starvation counter guarantees instruction fetch progress.

---
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: funnels I-fetch and D-access requests onto one RAM port.
// Data wins arbitration; a data-streak counter forces an instruction grant to avoid starvation.
module mem_arbiter #(
  parameter int unsigned MAX_DSTREAK = 4,
  parameter int unsigned TIMEOUT     = 64,
  parameter logic [31:0] ERR_WORD    = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        mem_err,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    D_WR = 2'd1,
    D_RD = 2'd2,
    I_RD = 2'd3
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);
  localparam logic [7:0] TCNT_LAST  = 8'(TIMEOUT - 1);
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_streak;
  logic [7:0]  r_tcnt;
  logic        r_err;
  logic        w_access;
  logic        w_tmo;
  logic        w_d_done;
  logic        w_i_done;
  logic        w_tmo_fire;

  assign w_access    = (ramstate == RAM_ACCESS);
  assign w_tmo       = (r_tcnt == TCNT_LAST);
  assign mem_err     = r_err;
  assign o_dbg_state = r_state;

  // A grant state whose request has dropped falls through with all RAM outputs at 0.
  always_comb begin
    w_next   = r_state;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'd0;
    ramstore = 32'd0;
    iload    = 32'd0;
    dload    = 32'd0;
    w_d_done = 1'b0;
    w_i_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (iREN && (r_streak == STREAK_MAX)) w_next = I_RD;
        else if (dWEN)                        w_next = D_WR;
        else if (dREN)                        w_next = D_RD;
        else if (iREN)                        w_next = I_RD;
        else                                  w_next = IDLE;
      end
      D_WR: begin
        if (!dWEN) begin
          w_next = IDLE;
        end else begin
          ramWEN   = 1'b1;
          ramaddr  = daddr;
          ramstore = dstore;
          if (w_access || w_tmo) begin
            w_d_done = 1'b1;
            w_next   = IDLE;
          end
        end
      end
      D_RD: begin
        if (!dREN) begin
          w_next = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = daddr;
          if (w_access || w_tmo) begin
            w_d_done = 1'b1;
            dload    = w_access ? ramload : ERR_WORD;
            w_next   = IDLE;
          end
        end
      end
      I_RD: begin
        if (!iREN) begin
          w_next = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (w_access || w_tmo) begin
            w_i_done = 1'b1;
            iload    = w_access ? ramload : ERR_WORD;
            w_next   = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign iwait      = iREN & ~w_i_done;
  assign dwait      = (dREN | dWEN) & ~w_d_done;
  assign w_tmo_fire = (w_d_done | w_i_done) & ~w_access;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= IDLE;
      r_streak <= 4'd0;
      r_tcnt   <= 8'd0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      // Counter sits at 0 in IDLE so every grant starts its wait budget fresh.
      if (r_state == IDLE)  r_tcnt <= 8'd0;
      else if (!w_access)   r_tcnt <= r_tcnt + 8'd1;
      if (w_i_done) begin
        r_streak <= 4'd0;
      end else if (w_d_done) begin
        if (!iREN)                         r_streak <= 4'd0;
        else if (r_streak != STREAK_MAX)   r_streak <= r_streak + 4'd1;
      end
      if (w_tmo_fire) r_err <= 1'b1;
    end
  end

endmodule
